instruction_prefetch_queue: RTL
===============================

Name: instruction_prefetch_queue

Overview:
Fetch-side prefetch buffer between instruction memory and the fetch/decode path of the sequential core. It autonomously issues word reads from a running fetch pointer and stores returned {PC, instruction} pairs in a small FIFO. It hands them to the decoder through a valid/ready handshake. A redirect input from the jump/branch logic flushes the buffer and restarts fetching at a new address, discarding any in-flight memory response.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
RESET_ADDRESS, 32'h0000_0000, first fetch address after reset

Ports:
CLK  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset
mem_request  output  1  read request to instruction memory, held high until mem_done
mem_address  output  32  word address of current request, stable while mem_request high
mem_done  input  1  one-cycle pulse: mem_rdata valid, request complete
mem_rdata  input  32  returned instruction word
instruction_valid  output  1  queue head valid
instruction  output  32  head instruction word
instruction_PC  output  32  PC of head instruction
instruction_ready  input  1  consumer accepts head this cycle
redirect  input  1  flush request (taken jump/branch)
redirect_address  input  32  new fetch address; bits[1:0] ignored (forced 0)
queue_count  output  $clog2(DEPTH)+1  current number of valid entries

Behaviour:
- Reset (reset=0, async): queue empty, queue_count=0, instruction_valid=0, mem_request=0, fetch pointer=RESET_ADDRESS, FSM=IDLE; instruction/instruction_PC=0.
- FSM states:
  - IDLE: assert mem_request next cycle when (queue_count + 0) < DEPTH and redirect=0; go to WAIT.
  - WAIT: mem_request=1, mem_address=fetch pointer. On mem_done: push {fetch pointer, mem_rdata}, fetch pointer += 4. If space remains after this push and pop, stay WAIT with the next address (back-to-back, no bubble); else go to IDLE.
  - DISCARD: mem_request stays 1 until mem_done, response dropped; then go to IDLE.
- Capacity rule: a request is issued only if queue_count plus the outstanding request is ≤ DEPTH. Push-on-full is therefore impossible; an internal assertion fires if it occurs.
- Max one outstanding request; mem_address/mem_request never change while waiting.
- Pop when instruction_valid & instruction_ready. Simultaneous push and pop keep the count unchanged.
- Head outputs are registered: an entry pushed at edge N is visible at edge N (valid after that edge), so there is 1-cycle memory-to-decoder latency.
- Redirect (sampled at edge) has priority over push and pop:
  - queue cleared, queue_count=0, instruction_valid=0 next cycle
  - fetch pointer = {redirect_address[31:2],2'b00}
  - in WAIT without mem_done in the same cycle: go to DISCARD
  - with mem_done in the same cycle: data dropped, go to IDLE
  - the first new request rises ≥1 cycle after the redirect edge
- Redirect in DISCARD: updates pointer again, stays DISCARD.
- Fetch pointer wraps 32'hFFFF_FFFC → 0 silently.
- Reset mid-request: everything cleared immediately. Memory-side abort is the memory's responsibility; a mem_done arriving after reset release while IDLE is ignored.

Optional Feature:
PREFETCH_BYPASS_EN
- Defined: when the queue is empty and mem_done arrives with no redirect, mem_rdata and the fetch pointer drive instruction/instruction_PC combinationally with instruction_valid=1 in the same cycle. If instruction_ready=1, the word is consumed without being written to the queue (0-cycle latency); otherwise it is written normally.
- Undefined: no combinational path from mem_* to instruction_*; 1-cycle latency always.

Test Plan:
- Reset, memory with 1-cycle mem_done latency, instruction_ready=1 → instruction_PC sequence 0,4,8,C… with words matching memory and no bubbles after the first; mem_address 0,4,8 back-to-back.
- instruction_ready=0, DEPTH=4 → exactly 4 requests; queue_count=4; mem_request stays 0. Ready raised for one cycle → count 3, one new request issued.
- Redirect to 32'h0000_0103 while a request to 32'h10 is pending, mem_done 3 cycles later → that response is dropped; next mem_address=32'h100; first delivered instruction_PC=32'h100.
- Redirect and mem_done in the same cycle, queue holding 2 entries → queue_count=0 next cycle, instruction_valid=0, the data never appears, next request to the redirect address.
- Fetch pointer at 32'hFFFF_FFF8 → delivers PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-WAIT with queue_count=2 → mem_request, instruction_valid and queue_count go to 0 without a clock edge; after release, fetch restarts at RESET_ADDRESS. With PREFETCH_BYPASS_EN: empty queue + mem_done + ready → instruction_valid in the same cycle, queue_count stays 0.

Source files
------------

// File: rtl/instruction_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetch_queue
// Purpose  : Fetch-side prefetch buffer. Autonomously reads instruction words
//            from a running fetch pointer (one outstanding request at most),
//            stores {PC, instruction} pairs in a small FIFO and presents the
//            head to the decoder through a valid/ready handshake. A redirect
//            flushes the queue, reloads the fetch pointer and drops any
//            response still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH              queue entries (power of two, >= 2)
//   RESET_ADDRESS      first fetch address after reset
// Ports:
//   CLK                core clock, rising edge
//   reset              asynchronous active-low reset
//   mem_request        read request, held until mem_done
//   mem_address        word address of the current request
//   mem_done           one-cycle completion pulse, mem_rdata valid
//   mem_rdata          returned instruction word
//   instruction_valid  queue head valid
//   instruction        head instruction word
//   instruction_PC     PC of head instruction
//   instruction_ready  consumer accepts head this cycle
//   redirect           flush and restart fetching
//   redirect_address   new fetch address (bits [1:0] forced to zero)
//   queue_count        number of valid entries
// Optional feature:
//   PREFETCH_BYPASS_EN when defined, a response arriving while the queue is
//                      empty is forwarded combinationally to the decoder and
//                      is only written to the queue if not accepted at once.
// ============================================================================
module instruction_prefetch_queue #(
  parameter int          DEPTH         = 4,
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     reset,
  output logic                     mem_request,
  output logic [31:0]              mem_address,
  input  logic                     mem_done,
  input  logic [31:0]              mem_rdata,
  output logic                     instruction_valid,
  output logic [31:0]              instruction,
  output logic [31:0]              instruction_PC,
  input  logic                     instruction_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_address,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_ptr, w_ptr_next;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_pc_q  [DEPTH];
  logic [31:0]     r_ins_q [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count, w_count_next;
  logic            w_resp, w_push, w_q_pop, w_q_valid;
  logic            w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^redirect_address[1:0];

  assign mem_request = (r_state != S_IDLE);
  assign mem_address = r_mem_addr;
  assign queue_count = r_count;

  // A response that is kept: arrives in WAIT and is not killed by a redirect.
  assign w_resp    = (r_state == S_WAIT) && mem_done && !redirect;
  assign w_q_valid = (r_count != '0);
  assign w_q_pop   = w_q_valid && instruction_ready;

`ifdef PREFETCH_BYPASS_EN
  logic w_bypass;
  // Empty queue: forward the response straight to the decoder. It only
  // occupies a queue slot when the decoder does not take it this cycle.
  assign w_bypass          = w_resp && !w_q_valid;
  assign w_push            = w_resp && !(w_bypass && instruction_ready);
  assign instruction_valid = w_q_valid || w_bypass;
  assign instruction       = w_bypass ? mem_rdata : r_ins_q[r_rd];
  assign instruction_PC    = w_bypass ? r_ptr     : r_pc_q[r_rd];
`else
  assign w_push            = w_resp;
  assign instruction_valid = w_q_valid;
  assign instruction       = r_ins_q[r_rd];
  assign instruction_PC    = r_pc_q[r_rd];
`endif

  assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_q_pop};

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    if (redirect) begin
      w_ptr_next = {redirect_address[31:2], 2'b00};
    end
    case (r_state)
      S_IDLE: begin
        if (!redirect && (r_count < c_full)) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // Response completing together with the redirect is simply dropped;
          // otherwise the in-flight request must still be drained.
          w_state_next = mem_done ? S_IDLE : S_DISCARD;
        end else if (mem_done) begin
          w_ptr_next   = r_ptr + 32'd4;
          w_state_next = (w_count_next < c_full) ? S_WAIT : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (mem_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= RESET_ADDRESS;
      r_mem_addr <= RESET_ADDRESS;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]  <= '0;
        r_ins_q[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      // The request address is only loaded when a request (re)starts, so it
      // stays frozen through WAIT and DISCARD even if the pointer moves.
      if (w_state_next == S_WAIT) begin
        r_mem_addr <= w_ptr_next;
      end
      if (redirect) begin
        r_count <= '0;
        r_wr    <= '0;
        r_rd    <= '0;
      end else begin
        if (w_push) begin
          r_pc_q[r_wr]  <= r_ptr;
          r_ins_q[r_wr] <= mem_rdata;
          r_wr          <= r_wr + AW'(1);
        end
        if (w_q_pop) begin
          r_rd <= r_rd + AW'(1);
        end
        r_count <= w_count_next;
      end
    end
  end

  // Issue gating guarantees a slot for every outstanding request.
  always_ff @(posedge CLK) begin
    if (reset && w_push) begin
      push_on_full: assert (r_count != c_full);
    end
  end

endmodule
`default_nettype wire
